rename_dispatch_wide: RTL

Next-generation rename/dispatch stage for the out-of-order core: each cycle it renames up to `DISPATCH_WIDTH` in-order instructions from the instruction queue and dispatches them to the reservation stations (RS), ROB and memory queue. It sits between the instruction queue and the RAT/free list on one side and the RS/ROB/memory queue on the other. Unlike the single-issue stage, it admits partial groups using credit counts, forwards dependences between instructions in the same group, and registers its dispatch outputs. It also tracks in-flight credits and honours a flush.

---
 rtl/rename_dispatch_wide_pkg.sv | 50 +++++
 rtl/rename_dispatch_wide_classify.sv | 36 +++
 rtl/rename_dispatch_wide.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rename_dispatch_wide_pkg.sv
// Shared types for the wide rename/dispatch stage: opcode/funct constants,
// RS class encoding and the registered dispatch packet.
package rename_dispatch_wide_pkg;

  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;
  localparam int MEMQ_W = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    RS_ALU = 3'd0,
    RS_MUL = 3'd1,
    RS_DIV = 3'd2,
    RS_BR  = 3'd3,
    RS_MEM = 3'd4
  } rs_class_e;

  typedef struct packed {
    logic [31:0]       inst;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       pc;
    logic [PREG_W-1:0] ps1;
    logic              ps1_valid;
    logic [PREG_W-1:0] ps2;
    logic              ps2_valid;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_idx;
    logic [MEMQ_W-1:0] mem_idx;
    rs_class_e         rs_sel;
  } dispatch_pkt_t;

endpackage

// File: rtl/rename_dispatch_wide_classify.sv
// Per-slot decode: RS class and whether the instruction allocates a pd.
module dispatch_classify
  import rename_dispatch_wide_pkg::*;
(
  input  logic [31:0] inst,
  output rs_class_e   cls,
  output logic        needs_pd
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       unused_srcs;

  assign opc         = inst[6:0];
  assign rd          = inst[11:7];
  assign f3          = inst[14:12];
  assign f7          = inst[31:25];
  assign unused_srcs = ^inst[24:15];

  always_comb begin
    cls = RS_ALU;
    if (opc == OPC_OP && f7 == F7_MULDIV) begin
      if (f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU}) cls = RS_MUL;
      else                                                  cls = RS_DIV;
    end else if (opc inside {OPC_JAL, OPC_JALR, OPC_BRANCH}) begin
      cls = RS_BR;
    end else if (opc inside {OPC_LOAD, OPC_STORE}) begin
      cls = RS_MEM;
    end
  end

  // Branches and stores carry immediate bits in the rd field.
  assign needs_pd = (rd != 5'd0) && (opc != OPC_BRANCH) && (opc != OPC_STORE);

endmodule

// File: rtl/rename_dispatch_wide.sv
// Wide rename/dispatch: credit-checked partial-group acceptance, intra-group
// dependence forwarding, and a registered dispatch stage.
module rename_dispatch_wide
  import rename_dispatch_wide_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 2,
  parameter int PHYS_REG_BITS  = PREG_W,  // must match the packet type
  parameter int ROB_IDX_BITS   = ROB_W,
  parameter int MEMQ_IDX_BITS  = MEMQ_W,
  parameter int RS_CNT_BITS    = 4,
  localparam int W  = DISPATCH_WIDTH,
  localparam int CW = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [W-1:0]                        iq_valid,
  input  logic [W-1:0][31:0]                  iq_inst,
  input  logic [W-1:0][31:0]                  iq_pc,
  output logic [CW-1:0]                       iq_deq_cnt,
  input  logic [PHYS_REG_BITS:0]              fl_count,
  input  logic [W-1:0][PHYS_REG_BITS-1:0]     fl_preg,
  output logic [CW-1:0]                       fl_deq_cnt,
  input  logic [ROB_IDX_BITS:0]               rob_free,
  input  logic [ROB_IDX_BITS-1:0]             rob_tail,
  input  logic [4:0][RS_CNT_BITS-1:0]         rs_free,
  input  logic [MEMQ_IDX_BITS-1:0]            memq_tail,
  output logic [W-1:0][4:0]                   rat_rs1,
  output logic [W-1:0][4:0]                   rat_rs2,
  input  logic [W-1:0][PHYS_REG_BITS-1:0]     rat_ps1,
  input  logic [W-1:0][PHYS_REG_BITS-1:0]     rat_ps2,
  input  logic [W-1:0]                        rat_ps1_valid,
  input  logic [W-1:0]                        rat_ps2_valid,
  output logic [W-1:0]                        rat_we,
  output logic [W-1:0][4:0]                   rat_rd,
  output logic [W-1:0][PHYS_REG_BITS-1:0]     rat_pd,
  output logic [W-1:0]                        disp_valid,
  output dispatch_pkt_t [W-1:0]               disp_pkt
);

  rs_class_e [W-1:0] cls;
  logic [W-1:0]      need_pd;

  for (genvar g = 0; g < W; g++) begin : g_cls
    dispatch_classify u_cls (.inst(iq_inst[g]), .cls(cls[g]), .needs_pd(need_pd[g]));
    assign rat_rs1[g] = iq_inst[g][19:15];
    assign rat_rs2[g] = iq_inst[g][24:20];
  end

  // Credits already handed to the output register but not yet visible downstream.
  logic [CW-1:0]      infl_rob;
  logic [4:0][CW-1:0] infl_cls;

  logic              go;
  logic [W-1:0]      acc;
  dispatch_pkt_t [W-1:0] pkt_d;
  int pd_used, mem_used, n_acc, rob_avail;
  int cls_used [5];
  int cls_avail [5];

  always_comb begin
    go        = rst_n && !flush;
    acc       = '0;
    pkt_d     = '0;
    pd_used   = 0;
    mem_used  = 0;
    n_acc     = 0;
    rob_avail = int'(rob_free) - int'(infl_rob);
    for (int k = 0; k < 5; k++) begin
      cls_used[k]  = 0;
      cls_avail[k] = int'(rs_free[k]) - int'(infl_cls[k]);
    end
    for (int i = 0; i < W; i++) begin
      // Once any slot fails, go stays low: no later slot can bypass it.
      go = go && iq_valid[i]
              && (pd_used + int'(need_pd[i]) <= int'(fl_count))
              && (i + 1 <= rob_avail)
              && (cls_used[int'(cls[i])] + 1 <= cls_avail[int'(cls[i])]);
      acc[i] = go;
      pkt_d[i].inst      = iq_inst[i];
      pkt_d[i].rd        = iq_inst[i][11:7];
      pkt_d[i].rs1       = iq_inst[i][19:15];
      pkt_d[i].rs2       = iq_inst[i][24:20];
      pkt_d[i].pc        = iq_pc[i];
      pkt_d[i].ps1       = rat_ps1[i];
      pkt_d[i].ps1_valid = rat_ps1_valid[i];
      pkt_d[i].ps2       = rat_ps2[i];
      pkt_d[i].ps2_valid = rat_ps2_valid[i];
      pkt_d[i].rob_idx   = rob_tail + ROB_IDX_BITS'(i);
      pkt_d[i].mem_idx   = memq_tail + MEMQ_IDX_BITS'(mem_used);
      pkt_d[i].rs_sel    = cls[i];
      for (int p = 0; p < i; p++) begin
        if (acc[p] && need_pd[p] && pkt_d[p].rd == pkt_d[i].rs1) begin
          pkt_d[i].ps1       = pkt_d[p].pd;
          pkt_d[i].ps1_valid = 1'b0;
        end
        if (acc[p] && need_pd[p] && pkt_d[p].rd == pkt_d[i].rs2) begin
          pkt_d[i].ps2       = pkt_d[p].pd;
          pkt_d[i].ps2_valid = 1'b0;
        end
      end
      if (go) begin
        if (need_pd[i]) begin
          pkt_d[i].pd = fl_preg[pd_used];
          pd_used     = pd_used + 1;
        end
        if (cls[i] == RS_MEM) mem_used = mem_used + 1;
        cls_used[int'(cls[i])] = cls_used[int'(cls[i])] + 1;
        n_acc = n_acc + 1;
      end
    end
  end

  // Only the youngest writer of a given rd updates the RAT.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      rat_we[i] = acc[i] && need_pd[i];
      rat_rd[i] = pkt_d[i].rd;
      rat_pd[i] = pkt_d[i].pd;
      for (int q = i + 1; q < W; q++)
        if (acc[q] && need_pd[q] && pkt_d[q].rd == pkt_d[i].rd) rat_we[i] = 1'b0;
    end
  end

  assign iq_deq_cnt = CW'(n_acc);
  assign fl_deq_cnt = CW'(pd_used);

  // Flush already forces acc and every count to zero through go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= '0;
      disp_pkt   <= '0;
      infl_rob   <= '0;
      infl_cls   <= '0;
    end else begin
      disp_valid <= acc;
      disp_pkt   <= pkt_d;
      infl_rob   <= CW'(n_acc);
      for (int k = 0; k < 5; k++) infl_cls[k] <= CW'(cls_used[k]);
    end
  end

endmodule
